// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard signal bundle: ID/EX/MEM status in, pipeline steering out.
// master drives the pipeline status; slave is the hazard control unit.
interface hazard_control_unit_if;
    logic [4:0] id_Rn;
    logic [4:0] id_Rm;
    logic       id_usesRm;
    logic [4:0] ex_Rd;
    logic       ex_memRead;
    logic       ex_brTaken;
    logic       mem_busy;
    logic       pcWrite;
    logic       ifidWrite;
    logic       idexBubble;
    logic       ifidFlush;
    logic       freeze;
    logic       memTimeout;

    modport master (
        output id_Rn, id_Rm, id_usesRm, ex_Rd,
        output ex_memRead, ex_brTaken, mem_busy,
        input  pcWrite, ifidWrite, idexBubble,
        input  ifidFlush, freeze, memTimeout
    );

    modport slave (
        input  id_Rn, id_Rm, id_usesRm, ex_Rd,
        input  ex_memRead, ex_brTaken, mem_busy,
        output pcWrite, ifidWrite, idexBubble,
        output ifidFlush, freeze, memTimeout
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch flush and memory-wait freeze with sticky timeout.
// Optional stall counter enabled by macro HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    hazard_control_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stallCycles
`endif
);
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] MAX_CNT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        TIMEOUT
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, cnt_nxt;
    logic          lu;
    logic          rn_hit, rm_hit;

    assign rn_hit = (hz.id_Rn == hz.ex_Rd);
    assign rm_hit = hz.id_usesRm & (hz.id_Rm == hz.ex_Rd);
    // XZR is never a real producer, so it cannot create a dependency
    assign lu = hz.ex_memRead & (hz.ex_Rd != 5'd31) & (rn_hit | rm_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        if (!hz.mem_busy)
            cnt_nxt = '0;
        else if (state != TIMEOUT)
            cnt_nxt = wait_cnt + WW'(1);
        unique case (state)
            RUN: begin
                if (hz.mem_busy)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (!hz.mem_busy)
                    state_nxt = RUN;
                else if (wait_cnt == MAX_CNT)
                    state_nxt = TIMEOUT;
            end
            TIMEOUT: state_nxt = TIMEOUT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        hz.memTimeout = (state == TIMEOUT);
        hz.freeze     = hz.mem_busy | (state == TIMEOUT);
        hz.pcWrite    = 1'b1;
        hz.ifidWrite  = 1'b1;
        hz.idexBubble = 1'b0;
        hz.ifidFlush  = 1'b0;
        // A frozen pipeline holds EX/ID, so branch and load-use wait
        if (hz.freeze) begin
            hz.pcWrite   = 1'b0;
            hz.ifidWrite = 1'b0;
        end else if (hz.ex_brTaken) begin
            hz.idexBubble = 1'b1;
            hz.ifidFlush  = 1'b1;
        end else if (lu) begin
            hz.pcWrite    = 1'b0;
            hz.ifidWrite  = 1'b0;
            hz.idexBubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallCycles <= '0;
        else if ((hz.freeze | ~hz.pcWrite) && (stallCycles != '1))
            stallCycles <= stallCycles + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed and random checks of hazard_control_unit against a counting model.
// Define HAZARD_PERF_CNT_EN to also check the stall counter.
module tb_hazard_control_unit;
    localparam int MW = 15;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_control_unit_if hif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
`endif

    hazard_control_unit #(
        .MAX_WAIT(MW),
        .CNT_W   (CW)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .hz   (hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCycles(stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;
    int busy_run = 0;
    bit timed_out = 0;
    int m_stall = 0;
    logic [5:0] exp_o;
    logic [5:0] got_o;

    // {pcWrite, ifidWrite, idexBubble, ifidFlush, freeze, memTimeout}
    function automatic logic [5:0] expect_out();
        bit hit, lu, frz;
        hit = (hif.id_Rn == hif.ex_Rd) ||
              (hif.id_usesRm && (hif.id_Rm == hif.ex_Rd));
        lu  = hif.ex_memRead && (hif.ex_Rd != 5'd31) && hit;
        frz = hif.mem_busy || timed_out;
        if (frz)            return {4'b0000, 1'b1, timed_out};
        if (hif.ex_brTaken) return 6'b111100;
        if (lu)             return 6'b001000;
        return 6'b110000;
    endfunction

    task automatic set(input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input bit um, input bit mr,
                       input bit br, input bit mb);
        hif.id_Rn      = rn;
        hif.id_Rm      = rm;
        hif.ex_Rd      = rd;
        hif.id_usesRm  = um;
        hif.ex_memRead = mr;
        hif.ex_brTaken = br;
        hif.mem_busy   = mb;
    endtask

    task automatic tick(input string tag);
        if (!rst) begin
            busy_run  = 0;
            timed_out = 0;
            m_stall   = 0;
        end
        #1;
        exp_o = expect_out();
        got_o = {hif.pcWrite, hif.ifidWrite, hif.idexBubble,
                 hif.ifidFlush, hif.freeze, hif.memTimeout};
        checks++;
        assert (got_o === exp_o) else begin
            errors++;
            $error("FAIL %s: outputs got=%b want=%b", tag, got_o, exp_o);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cycles === CW'(m_stall)) else begin
            errors++;
            $error("FAIL %s: stallCycles got=%0d want=%0d",
                   tag, stall_cycles, m_stall);
        end
`endif
        @(posedge clk);
        if (rst) begin
            if ((exp_o[1] || !exp_o[5]) && (m_stall < (2 ** CW) - 1))
                m_stall++;
            if (!timed_out) begin
                if (hif.mem_busy) begin
                    busy_run++;
                    if (busy_run > MW) timed_out = 1;
                end else begin
                    busy_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_reg();
        logic [4:0] r;
        r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        rst = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick("reset");
        set(0, 0, 0, 0, 0, 0, 1);
        tick("reset_busy");
        set(0, 0, 0, 0, 0, 0, 0);
        tick("reset_idle");
        rst = 1'b1;

        set(5, 0, 5, 0, 1, 0, 0);
        tick("lu_stall");
        set(5, 0, 5, 0, 0, 0, 0);
        tick("lu_release");
        set(31, 0, 31, 0, 1, 0, 0);
        tick("xzr");
        set(0, 7, 7, 0, 1, 0, 0);
        tick("rm_unused");
        set(0, 7, 7, 1, 1, 0, 0);
        tick("rm_used");
        set(5, 0, 5, 0, 1, 1, 0);
        tick("br_over_lu");
        set(1, 2, 3, 0, 0, 1, 0);
        tick("branch");

        set(5, 0, 5, 0, 1, 1, 1);
        repeat (15) tick("busy15");
        set(5, 0, 5, 0, 1, 0, 0);
        tick("busy15_release");
        set(0, 0, 0, 0, 0, 0, 0);
        tick("run_after_wait");

        set(5, 0, 5, 0, 1, 0, 1);
        repeat (16) tick("busy16");
        set(5, 0, 5, 0, 1, 1, 0);
        repeat (3) tick("timeout_sticky");
        rst = 1'b0;
        tick("timeout_reset");
        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0);
        tick("after_timeout_reset");

        set(0, 0, 0, 0, 0, 0, 1);
        repeat (6) tick("wait_pre_reset");
        rst = 1'b0;
        tick("reset_mid_wait");
        rst = 1'b1;
        repeat (15) tick("wait_after_reset");
        set(0, 0, 0, 0, 0, 0, 0);
        tick("wait_after_reset_idle");

        for (int i = 0; i < 600; i++) begin
            set(rnd_reg(), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0));
            rst = ($urandom_range(0, 60) != 0);
            tick("random");
        end
        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 1);
        repeat (17) tick("random_timeout");

        rst = 1'b0;
        set(5, 0, 5, 0, 1, 0, 0);
        tick("perf_reset");
        rst = 1'b1;
        repeat (20) tick("perf_stall");
        set(5, 0, 5, 0, 1, 0, 1);
        repeat (3) tick("perf_busy");
        rst = 1'b0;
        tick("perf_reset_mid_stall");
        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0);
        tick("perf_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
